modulo_controlador_varredura: RTL and testbench
===============================================

MODULO_CONTROLADOR_VARREDURA -- requirements
Module: modulo_controlador_varredura

Interface
REQ-001 Parameter: DIV, default 4, number of clk cycles each column is driven (range 1..255).
REQ-002 Parameter: NCOL, default 5, number of scanned columns (range 1..8).
REQ-003 Parameter: NROW, default 7, number of selectable row positions (range 1..8).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  scan enable; level sampled each clk.
REQ-007 btn_up  input  1  asynchronous push-button, move row position up.
REQ-008 btn_dn  input  1  asynchronous push-button, move row position down.
REQ-009 mdc  output  3  current column index, registered.
REQ-010 mdl  output  3  current row position, registered.
REQ-011 col_en  output  1  column drive enable; low during blanking and idle.
REQ-012 frame_tick  output  1  one-cycle pulse marking the last blank of a frame.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and BLANK.
REQ-014 In IDLE, the block SHALL hold col_en=0 and mdc=0. It SHALL go to SCAN on the next edge when en=1.
REQ-015 On entry to SCAN, the dwell counter SHALL be 0. SCAN SHALL hold col_en=1 and SHALL last exactly DIV cycles, with the counter running 0..DIV-1.
REQ-016 At counter==DIV-1, SCAN SHALL go to BLANK. BLANK SHALL last exactly 1 cycle with col_en=0.
REQ-017 On the BLANK->SCAN transition, mdc SHALL advance by 1. From NCOL-1 it SHALL wrap to 0.
REQ-018 A frame SHALL be exactly NCOL*(DIV+1) cycles.
REQ-019 frame_tick SHALL be 1 only during the BLANK cycle in which mdc==NCOL-1.
REQ-020 When en=0 is sampled in any state, the next state SHALL be IDLE, with mdc=0 and counter=0 on that same edge. Any pending moves SHALL be kept.
REQ-021 btn_up and btn_dn SHALL each pass through a 2-flop synchronizer and then a rising-edge detector. A press SHALL set its pending flag 3 edges after the button first reads high.
REQ-022 A pending flag SHALL remain set until it is applied. Repeated presses before application SHALL NOT accumulate.
REQ-023 Pending moves SHALL be applied on the edge that ends the frame_tick cycle, or on the next edge while in IDLE. Both flags SHALL clear on application.
REQ-024 Application rules:
- up only: mdl+1, saturating at NROW-1.
- down only: mdl-1, saturating at 0.
- both pending: mdl unchanged.
REQ-025 mdl SHALL never change mid-frame while scanning (tear-free display).
REQ-026 mdc SHALL always be within 0..NCOL-1 and mdl within 0..NROW-1. No other values SHALL appear on these outputs.

Reset
REQ-027 While rst=1, independent of clk, the block SHALL hold:
- state=IDLE
- mdc=0, mdl=0
- col_en=0, frame_tick=0
- counter=0
- pending flags=0
- synchronizer and edge-detector flops=0
REQ-028 Reset asserted mid-frame SHALL abort the scan immediately. After release, the first SCAN SHALL start at mdc=0 and counter=0.
REQ-029 Button edges occurring while rst=1 SHALL be discarded.

Structure
REQ-030 State encodings (IDLE=2'd0, SCAN=2'd1, BLANK=2'd2) and the default NCOL/NROW/DIV values SHALL live in the shared definitions package matriz_pkg.
REQ-031 Synchronizer plus rising-edge detection SHALL be the sub-module modulo_detector_borda, instantiated once per button.
REQ-032 mdc/mdl SHALL connect directly to modulo_seletor_1_8 inputs. col_en SHALL gate the column drivers externally.

Verification (DIV=4, NCOL=5, NROW=7)
REQ-033 Reset release, en=1 held:
- mdc sequence 0,1,2,3,4,0.
- Each column: 4 cycles col_en=1, then 1 cycle col_en=0.
- frame_tick every 25 cycles.
REQ-034 One btn_up press at mdl=0 mid-frame:
- mdl stays 0 until the frame_tick cycle, then reads 1 on the next cycle.
- Three presses within one frame give mdl=1, not 3.
REQ-035 Saturation:
- mdl=6 plus btn_up -> mdl stays 6.
- mdl=0 plus btn_dn -> mdl stays 0.
- btn_up and btn_dn pressed in the same frame from mdl=3 -> mdl=3.
REQ-036 en dropped at mdc=2, counter=1:
- Next cycle: IDLE, mdc=0, col_en=0.
- A pending up applied next edge: mdl 3->4.
- en re-raised: scan restarts at mdc=0 with a full 4-cycle dwell.
REQ-037 rst pulsed asynchronously at mdc=3, mdl=5 between clk edges:
- Outputs go to 0 immediately.
- After release with en=1, the frame restarts at mdc=0.
- A button pressed during reset has no effect.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix scan controller: FSM encoding and default geometry.
package matriz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } estado_t;

    localparam int NCOL_DEF = 5;
    localparam int NROW_DEF = 7;
    localparam int DIV_DEF  = 4;

endpackage

// File: rtl/modulo_detector_borda.sv
// Two-flop synchronizer for an asynchronous push-button followed by a rising-edge detector.
module modulo_detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic borda
);

    logic sync_1;
    logic sync_2;
    logic anterior;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            anterior <= 1'b0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            anterior <= sync_2;
        end
    end

    assign borda = sync_2 & ~anterior;

endmodule

// File: rtl/modulo_controlador_varredura.sv
// Column scan controller for a dot matrix, with a row position moved by debounced buttons.
//  state | meaning
//  IDLE  | scan stopped, col_en=0, mdc=0; pending row moves applied each edge
//  SCAN  | column mdc driven for DIV cycles
//  BLANK | one blanking cycle between columns; frame_tick on the last column
module modulo_controlador_varredura
    import matriz_pkg::*;
#(
    parameter int DIV  = DIV_DEF,
    parameter int NCOL = NCOL_DEF,
    parameter int NROW = NROW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [2:0] mdc,
    output logic [2:0] mdl,
    output logic       col_en,
    output logic       frame_tick
);

    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);
    localparam logic [2:0] COL_LAST = 3'(NCOL - 1);
    localparam logic [2:0] ROW_LAST = 3'(NROW - 1);

    estado_t    estado, estado_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] mdc_nxt, mdl_nxt;
    logic       pend_up, pend_dn;
    logic       borda_up, borda_dn;
    logic       aplica;

    modulo_detector_borda u_det_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .borda (borda_up)
    );

    modulo_detector_borda u_det_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dn),
        .borda (borda_dn)
    );

    assign col_en     = (estado == SCAN);
    assign frame_tick = (estado == BLANK) && (mdc == COL_LAST);
    // Row moves only land at frame boundaries (or while stopped) so a frame never tears.
    assign aplica     = frame_tick || (estado == IDLE);

    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = cnt;
        mdc_nxt    = mdc;
        if (!en) begin
            estado_nxt = IDLE;
            cnt_nxt    = 8'd0;
            mdc_nxt    = 3'd0;
        end else begin
            case (estado)
                IDLE: begin
                    estado_nxt = SCAN;
                    cnt_nxt    = 8'd0;
                    mdc_nxt    = 3'd0;
                end
                SCAN: begin
                    if (cnt == CNT_LAST) begin
                        estado_nxt = BLANK;
                        cnt_nxt    = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                BLANK: begin
                    estado_nxt = SCAN;
                    mdc_nxt    = (mdc == COL_LAST) ? 3'd0 : mdc + 3'd1;
                end
                default: begin
                    estado_nxt = IDLE;
                    cnt_nxt    = 8'd0;
                    mdc_nxt    = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        mdl_nxt = mdl;
        if (aplica) begin
            if (pend_up && !pend_dn && mdl != ROW_LAST)
                mdl_nxt = mdl + 3'd1;
            else if (pend_dn && !pend_up && mdl != 3'd0)
                mdl_nxt = mdl - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= IDLE;
            cnt     <= 8'd0;
            mdc     <= 3'd0;
            mdl     <= 3'd0;
            pend_up <= 1'b0;
            pend_dn <= 1'b0;
        end else begin
            estado  <= estado_nxt;
            cnt     <= cnt_nxt;
            mdc     <= mdc_nxt;
            mdl     <= mdl_nxt;
            // A press arriving on the application edge is kept for the next frame.
            pend_up <= aplica ? borda_up : (pend_up | borda_up);
            pend_dn <= aplica ? borda_dn : (pend_dn | borda_dn);
        end
    end

endmodule

// File: tb/tb_modulo_controlador_varredura.sv
// Directed bench for the scan controller with DIV=4, NCOL=5, NROW=7.
module tb_modulo_controlador_varredura;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [2:0] mdc;
    logic [2:0] mdl;
    logic       col_en;
    logic       frame_tick;

    int n_chk = 0;
    int n_fail = 0;

    modulo_controlador_varredura #(.DIV(4), .NCOL(5), .NROW(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .mdc        (mdc),
        .mdl        (mdl),
        .col_en     (col_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic up;
        logic dn;
        int   mdc;
        int   mdl;
        logic col_en;
        logic tick;
    } vec_t;

    vec_t tab[26];

    task automatic chk(input string nome, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic frame_press(input logic up, input logic dn, input int old_mdl,
                               input int exp_mdl, input string nome);
        bit ok;
        btn_up = up;
        btn_dn = dn;
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        wait_tick(ok);
        chk({nome, "_tick_seen"}, int'(ok), 1);
        chk({nome, "_hold"}, int'(mdl), old_mdl);
        @(negedge clk);
        chk(nome, int'(mdl), exp_mdl);
    endtask

    task automatic wait_mdc(input int alvo, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (int'(mdc) == alvo) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int per;

        // one frame after reset release, three btn_up presses that must merge into one move
        tab[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tab[1]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tab[3]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
        tab[4]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        tab[5]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
        tab[6]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
        tab[7]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
        tab[8]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
        tab[9]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
        tab[10] = '{1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0};
        tab[11] = '{1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0};
        tab[12] = '{1'b1, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0};
        tab[13] = '{1'b1, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0};
        tab[14] = '{1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0};
        tab[15] = '{1'b1, 1'b1, 1'b0, 3, 0, 1'b1, 1'b0};
        tab[16] = '{1'b1, 1'b1, 1'b0, 3, 0, 1'b1, 1'b0};
        tab[17] = '{1'b1, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0};
        tab[18] = '{1'b1, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0};
        tab[19] = '{1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0};
        tab[20] = '{1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0};
        tab[21] = '{1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0};
        tab[22] = '{1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0};
        tab[23] = '{1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0};
        tab[24] = '{1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 1'b1};
        tab[25] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0};

        #2;
        chk("rst_mdc", int'(mdc), 0);
        chk("rst_mdl", int'(mdl), 0);
        chk("rst_col_en", int'(col_en), 0);
        chk("rst_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_col_en", int'(col_en), 0);
            chk("idle_mdc", int'(mdc), 0);
        end

        for (int i = 0; i < 26; i++) begin
            en     = tab[i].en;
            btn_up = tab[i].up;
            btn_dn = tab[i].dn;
            @(negedge clk);
            chk($sformatf("tab%0d_mdc", i), int'(mdc), tab[i].mdc);
            chk($sformatf("tab%0d_mdl", i), int'(mdl), tab[i].mdl);
            chk($sformatf("tab%0d_col_en", i), int'(col_en), int'(tab[i].col_en));
            chk($sformatf("tab%0d_tick", i), int'(frame_tick), int'(tab[i].tick));
        end

        // frame period between consecutive ticks
        wait_tick(ok);
        chk("period_first_tick", int'(ok), 1);
        per = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                per = i;
                break;
            end
        end
        chk("frame_period", per, 25);
        @(negedge clk);

        frame_press(1'b1, 1'b0, 1, 2, "up_1_2");
        frame_press(1'b1, 1'b0, 2, 3, "up_2_3");
        frame_press(1'b1, 1'b0, 3, 4, "up_3_4");
        frame_press(1'b1, 1'b0, 4, 5, "up_4_5");
        frame_press(1'b1, 1'b0, 5, 6, "up_5_6");
        frame_press(1'b1, 1'b0, 6, 6, "up_sat_6");
        frame_press(1'b0, 1'b1, 6, 5, "dn_6_5");
        frame_press(1'b0, 1'b1, 5, 4, "dn_5_4");
        frame_press(1'b0, 1'b1, 4, 3, "dn_4_3");
        frame_press(1'b1, 1'b1, 3, 3, "both_3");

        // en dropped at mdc=2, counter=1 with an up move pending
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        wait_mdc(2, ok);
        chk("en_drop_reach_mdc2", int'(ok), 1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_mdc", int'(mdc), 0);
        chk("en_drop_col_en", int'(col_en), 0);
        chk("en_drop_mdl_hold", int'(mdl), 3);
        @(negedge clk);
        chk("idle_apply_mdl", int'(mdl), 4);
        chk("idle_col_en2", int'(col_en), 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("restart_dwell%0d_col_en", i), int'(col_en), 1);
            chk($sformatf("restart_dwell%0d_mdc", i), int'(mdc), 0);
        end
        @(negedge clk);
        chk("restart_blank_col_en", int'(col_en), 0);
        @(negedge clk);
        chk("restart_next_mdc", int'(mdc), 1);
        chk("restart_next_col_en", int'(col_en), 1);

        frame_press(1'b1, 1'b0, 4, 5, "up_4_5b");

        // asynchronous reset mid-frame at mdc=3, mdl=5
        wait_mdc(3, ok);
        chk("rst_reach_mdc3", int'(ok), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mdc", int'(mdc), 0);
        chk("async_rst_mdl", int'(mdl), 0);
        chk("async_rst_col_en", int'(col_en), 0);
        chk("async_rst_tick", int'(frame_tick), 0);
        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        @(negedge clk);
        chk("in_rst_col_en", int'(col_en), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_dwell%0d_col_en", i), int'(col_en), 1);
            chk($sformatf("post_rst_dwell%0d_mdc", i), int'(mdc), 0);
        end
        @(negedge clk);
        chk("post_rst_blank", int'(col_en), 0);
        wait_tick(ok);
        chk("post_rst_tick_seen", int'(ok), 1);
        chk("post_rst_tick_mdc", int'(mdc), 4);
        @(negedge clk);
        chk("post_rst_btn_ignored", int'(mdl), 0);
        chk("post_rst_wrap_mdc", int'(mdc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
